// File: rtl/gates_spec_decoder.sv
// Receive-side checker/decoder for {and,or,xor,nand,nor,xnor,anotb} gate vectors with an output FIFO.
// Optional saturating illegal-word counter is enabled by defining GATES_DEC_ERRCNT_EN.
module gates_spec_decoder #(
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 8,
    parameter int DROP_ERR = 0
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_a,
    output logic             out_b,
    output logic             out_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [2:0]  mem [DEPTH];
    logic        dec_a;
    logic        dec_b;
    logic        dec_err;
    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        dec_a   = 1'b0;
        dec_b   = 1'b0;
        dec_err = 1'b0;
        case (in_vec)
            7'h0E: ;
            7'h38: dec_b = 1'b1;
            7'h39: dec_a = 1'b1;
            7'h62: begin
                dec_a = 1'b1;
                dec_b = 1'b1;
            end
            default: dec_err = 1'b1;
        endcase
    end

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign push      = accept && !(dec_err && (DROP_ERR != 0));
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (accept && dec_err)
                err_sticky <= 1'b1;
        end
    end

    // Storage is deliberately left unreset; only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {dec_a, dec_b, dec_err};
    end

    assign {out_a, out_b, out_err} = mem[rd_ptr[AW-1:0]];

`ifdef GATES_DEC_ERRCNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)
            cnt_q <= '0;
        else if (accept && dec_err && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_ONE;
    end

    assign err_count = cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_gates_spec_decoder.sv
// Scoreboard bench: dut0 queues illegal words (CNT_W=2 for saturation), dut1 drops them.
module tb_gates_spec_decoder;

`ifdef GATES_DEC_ERRCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic [2:0] abe;
        int         acc;
        bit         exact;
    } exp_t;

    logic            clk = 1'b0;
    logic            areset_n = 1'b0;
    logic [1:0]      in_valid = '0;
    logic [1:0]      in_ready;
    logic [1:0][6:0] in_vec = '0;
    logic [1:0]      out_valid;
    logic [1:0]      out_ready = '0;
    logic [1:0]      out_a;
    logic [1:0]      out_b;
    logic [1:0]      out_err;
    logic [1:0]      err_sticky;
    logic [1:0]      cnt0;
    logic [7:0]      cnt1;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    gates_spec_decoder #(.DEPTH(4), .CNT_W(2), .DROP_ERR(0)) dut0 (
        .clk(clk), .areset_n(areset_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_vec(in_vec[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_a(out_a[0]), .out_b(out_b[0]), .out_err(out_err[0]),
        .err_sticky(err_sticky[0]), .err_count(cnt0)
    );

    gates_spec_decoder #(.DEPTH(4), .CNT_W(8), .DROP_ERR(1)) dut1 (
        .clk(clk), .areset_n(areset_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_vec(in_vec[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_a(out_a[1]), .out_b(out_b[1]), .out_err(out_err[1]),
        .err_sticky(err_sticky[1]), .err_count(cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_cnt(input int n, input int maxv);
        if (!CNT_ON)
            return 0;
        return (n > maxv) ? maxv : n;
    endfunction

    // Pops the scoreboard for DUT d; called on the negedge before the popping edge.
    task automatic monitor_pop(input int d);
        exp_t e;
        logic [2:0] act;
        int sz;
        act = {out_a[d], out_b[d], out_err[d]};
        sz = (d == 0) ? q0.size() : q1.size();
        n_chk++;
        if (sz == 0) begin
            n_err++;
            $display("FAIL unexpected_out%0d: got abe=%b expected no output", d, act);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (act !== e.abe) begin
            n_err++;
            $display("FAIL data%0d: got abe=%b expected abe=%b", d, act, e.abe);
        end
        if (e.exact)
            check($sformatf("latency%0d", d), cyc, e.acc);
    endtask

    always @(negedge clk)
        if (areset_n && out_valid[0] && out_ready[0]) monitor_pop(0);
    always @(negedge clk)
        if (areset_n && out_valid[1] && out_ready[1]) monitor_pop(1);

    // Drives a word after the next edge and returns on the negedge where it is seen accepted.
    task automatic push(input int d, input logic [6:0] v, input logic [2:0] abe,
                        input bit exact, input bit queued);
        exp_t e;
        int budget;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b1;
        in_vec[d]   = v;
        budget = 0;
        @(negedge clk);
        while (!in_ready[d] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready[d]) begin
            n_chk++;
            n_err++;
            $display("FAIL accept_timeout%0d: got in_ready=0 expected 1", d);
        end else if (queued) begin
            e.abe = abe;
            e.acc = cyc + 1;
            e.exact = exact;
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic idle(input int d);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_in_ready0", in_ready[0], 1);
        check("rst_in_ready1", in_ready[1], 1);
        check("rst_out_valid0", out_valid[0], 0);
        check("rst_sticky0", err_sticky[0], 0);
        check("rst_count0", cnt0, 0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;

        // Legal sweep, streaming with latency checks
        out_ready[0] = 1'b1;
        push(0, 7'h0E, 3'b000, 1, 1);
        push(0, 7'h38, 3'b010, 1, 1);
        push(0, 7'h39, 3'b100, 1, 1);
        push(0, 7'h62, 3'b110, 1, 1);
        idle(0);
        repeat (3) @(negedge clk);
        check("legal_sticky0", err_sticky[0], 0);
        check("legal_count0", cnt0, 0);

        // Illegal word queued with out_err
        push(0, 7'h7F, 3'b001, 1, 1);
        idle(0);
        check("ill_sticky0", err_sticky[0], 1);
        check("ill_count0", cnt0, exp_cnt(1, 3));

        // Dropping variant: the middle word produces no entry
        out_ready[1] = 1'b1;
        push(1, 7'h0E, 3'b000, 1, 1);
        push(1, 7'h00, 3'b000, 0, 0);
        push(1, 7'h62, 3'b110, 1, 1);
        idle(1);
        check("drop_sticky1", err_sticky[1], 1);
        check("drop_count1", cnt1, exp_cnt(1, 255));
        repeat (3) @(negedge clk);
        check("drop_empty1", out_valid[1], 0);

        // Backpressure: fill, then release with the fifth word held
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        push(0, 7'h0E, 3'b000, 0, 1);
        push(0, 7'h38, 3'b010, 0, 1);
        push(0, 7'h39, 3'b100, 0, 1);
        push(0, 7'h62, 3'b110, 0, 1);
        @(posedge clk);
        #1;
        in_vec[0] = 7'h38;
        @(negedge clk);
        check("bp_full", in_ready[0], 0);
        check("bp_valid", out_valid[0], 1);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_no_comb_ready", in_ready[0], 0);
        @(negedge clk);
        check("bp_resume", in_ready[0], 1);
        q0.push_back('{abe: 3'b010, acc: cyc + 1, exact: 1'b0});
        idle(0);
        repeat (6) @(negedge clk);

        // Saturation with CNT_W=2: five more illegal words
        push(0, 7'h7F, 3'b001, 1, 1);
        push(0, 7'h00, 3'b001, 1, 1);
        idle(0);
        check("sat_count_mid", cnt0, exp_cnt(3, 3));
        push(0, 7'h7F, 3'b001, 1, 1);
        push(0, 7'h01, 3'b001, 1, 1);
        push(0, 7'h7E, 3'b001, 1, 1);
        idle(0);
        check("sat_count", cnt0, exp_cnt(6, 3));
        repeat (3) @(negedge clk);

        // Reset mid-traffic discards queued entries
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        push(0, 7'h0E, 3'b000, 0, 1);
        push(0, 7'h62, 3'b110, 0, 1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        areset_n = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        check("mid_rst_in_ready", in_ready[0], 1);
        check("mid_rst_out_valid", out_valid[0], 0);
        check("mid_rst_sticky", err_sticky[0], 0);
        check("mid_rst_count", cnt0, 0);
        check("mid_rst_sticky1", err_sticky[1], 0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        out_ready[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_empty", out_valid[0], 0);

        // Post-reset traffic still flows
        push(0, 7'h39, 3'b100, 1, 1);
        idle(0);
        repeat (5) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/gates_spec_decoder.md
# gates_spec_decoder

Receive-side decoder for the seven-output two-input gate vector {and, or, xor, nand, nor, xnor, anotb}. It accepts vectors over a valid/ready stream and checks each one against the four legal codewords. It recovers the operand pair (a, b) and buffers results in a small FIFO for a downstream valid/ready consumer. It sits at the far end of any link that carries gate-vector words and flags corrupted words instead of passing them silently.

## Interface
Parameters:
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of error counter.
- DROP_ERR, 0, 1 = illegal words are consumed but not queued; 0 = queued with out_err=1.

Ports:
- clk  in  1  single clock, rising edge.
- areset_n  in  1  asynchronous active-low reset, applied immediately, released synchronously by the integrator.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder can accept; equals !full.
- in_vec  in  7  bit6 and, bit5 or, bit4 xor, bit3 nand, bit2 nor, bit1 xnor, bit0 anotb.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head entry.
- out_a  out  1  decoded a (0 when out_err=1).
- out_b  out  1  decoded b (0 when out_err=1).
- out_err  out  1  head entry came from an illegal word.
- err_sticky  out  1  set by any accepted illegal word; cleared only by reset.
- err_count  out  CNT_W  accepted illegal words, saturating (see Configuration).

## Operation
- Legal codewords: (a,b)=(0,0) → 7'h0E; (0,1) → 7'h38; (1,0) → 7'h39; (1,1) → 7'h62. Any other value is illegal.
- Input accept when in_valid && in_ready. Decode is combinational on in_vec. The entry {a,b,err} is written to the FIFO tail in the same edge.
- DROP_ERR=1: an illegal word is accepted and raises err_sticky/err_count, but writes no FIFO entry.
- Output pop when out_valid && out_ready. The head advances at that edge.
- FIFO: binary read/write pointers of log2(DEPTH)+1 bits, wrapping naturally. full = MSBs differ and the rest are equal. empty = pointers equal.
- Full: in_ready=0 even if a pop occurs in the same cycle; there is no combinational ready path from out_ready.
- Empty: out_valid=0. out_a/out_b/out_err hold the last-read storage value and are don't-care.
- Simultaneous push and pop when neither full nor empty: both occur and the occupancy is unchanged.
- Push into empty FIFO: entry is visible on out_valid the next cycle; there is no bypass.
- Reset assertion at any time: pointers go to 0 and the FIFO contents are discarded. out_valid=0, in_ready=1, err_sticky=0, err_count=0. Storage contents are not reset.

## Timing
- Latency: accepted input at edge N; out_valid=1 with that entry after edge N (cycle N+1).
- Throughput: one word per cycle in both directions while the FIFO is neither full nor empty.
- in_ready and out_valid are registered-state decodes with no input-to-output combinational path.
- err_sticky and err_count update at the edge that accepts the illegal word.

## Configuration
- GATES_DEC_ERRCNT_EN defined: err_count increments on each accepted illegal word and saturates at 2^CNT_W−1.
- Not defined: err_count is tied to 0 and no counter logic is built. err_sticky is unaffected.

## Test plan
- Reset: hold areset_n=0 mid-traffic → in_ready=1, out_valid=0, err_sticky=0, err_count=0, and the FIFO is empty after release.
- Legal sweep: push 7'h0E, 7'h38, 7'h39, 7'h62 with out_ready=1 → (a,b) out = 00, 01, 10, 11; each appears one cycle after its accept; out_err=0.
- Illegal word, DROP_ERR=0: push 7'h7F → out_err=1, out_a=0, out_b=0; err_sticky=1; err_count=1 (macro on) or 0 (macro off).
- Illegal word, DROP_ERR=1: push 7'h0E, 7'h00, 7'h62 → only two outputs (00, 11); err_count=1.
- Backpressure: out_ready=0, push 5 words with DEPTH=4 → in_ready=0 after the 4th accept. Then raise out_ready with in_valid held → in_ready returns only after the first pop; order is preserved.
- Saturation: with the macro on and CNT_W=2, push 5 illegal words → err_count stays at 3.
